button_bank: RTL and testbench
==============================

# button_bank

Parametrised bank of N debounced push-button channels that replaces single-button toggle logic throughout the design. Each channel synchronises an asynchronous raw input, rejects bounce with a per-channel counter, and produces four outputs: a clean level, one-cycle press and release pulses, and a latched toggle state. An optional long-press detector can be compiled in. The block sits between board-level button pins and any control FSM that consumes user input.

## Interface
- N, 4, number of independent button channels (≥1)
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to accept a new level (≥1)
- HOLD_CYCLES, 1000, cycles the accepted level must stay high before a long-press pulse fires (≥1; used only with BUTTON_BANK_HOLD_EN)
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- buttons_raw  input  N  raw asynchronous button levels, 1 = pressed
- clear_toggle  input  N  synchronous per-channel clear of toggle state
- level  output  N  debounced level
- press_pulse  output  N  one-cycle pulse on accepted 0→1
- release_pulse  output  N  one-cycle pulse on accepted 1→0
- toggle  output  N  flips on every accepted press
- hold_pulse  output  N  one-cycle long-press pulse (constant 0 without BUTTON_BANK_HOLD_EN)

## Operation
- Reset: every output is 0; synchroniser flops 0; all channels in LOW; all counters 0.
- Two-flop synchroniser per channel; the FSM sees only the second flop (sync).
- Per-channel FSM states: LOW, DEB_HIGH, HIGH, DEB_LOW.
  - LOW: sync=1 → DEB_HIGH, cnt=1; if DEBOUNCE_CYCLES=1, go straight to HIGH.
  - DEB_HIGH: sync=0 → LOW, cnt=0 (glitch rejected, no pulse); sync=1 and cnt=DEBOUNCE_CYCLES-1 → HIGH, level=1, press_pulse=1, toggle inverted; otherwise cnt+1.
  - HIGH: the mirror of LOW, moving to DEB_LOW.
  - DEB_LOW: the mirror of DEB_HIGH; on commit → LOW, level=0, release_pulse=1.
- Counter width is $clog2(DEBOUNCE_CYCLES+1); it never wraps, because it resets on every state change.
- clear_toggle[i]=1 sets toggle[i]=0 on the next edge. If it coincides with an accepted press, clear wins and toggle is 0.
- Channels are fully independent. Simultaneous events on different channels are handled in the same cycle with no arbitration.
- Reset asserted mid-debounce discards all progress. No pulse is emitted on reset entry or exit.

## Timing
- Let edge 0 be the first edge at which buttons_raw[i] is sampled stably high. sync is high after edge 1. level[i] and press_pulse[i] go high after edge DEBOUNCE_CYCLES+1.
- Release latency is identical, measured to level=0 and release_pulse=1.
- Each pulse is high for exactly one cycle.
- toggle changes on the same edge as press_pulse.
- Any sync glitch shorter than DEBOUNCE_CYCLES samples produces no output change.

## Configuration
- BUTTON_BANK_HOLD_EN defined:
  - A per-channel hold counter runs while the channel is in HIGH or DEB_LOW.
  - hold_pulse[i] fires once, HOLD_CYCLES cycles after press_pulse[i].
  - The counter then saturates, so there is no repeat.
  - The counter clears on entry to LOW.
- BUTTON_BANK_HOLD_EN undefined: the hold counters are absent and hold_pulse is tied to 0.

## Structure
- Package button_pkg holds:
  - the state enum btn_state_t (LOW, DEB_HIGH, HIGH, DEB_LOW);
  - a counter-width helper function;
  - default parameter constants.
- Sub-module button_channel holds one channel: synchroniser, FSM, debounce counter, toggle, and optional hold counter. button_bank instantiates it N times in a generate loop.

## Test plan
- N=4, DEBOUNCE_CYCLES=4: hold raw[0]=1 from edge 0. Expect level[0]=1, press_pulse[0] high one cycle, and toggle[0]=1, all after edge 5. Other channels stay 0.
- Bounce: raw[1] pattern 1,0,1,1,0 then steady 1. No pulse until 4 consecutive sync highs. Exactly one press_pulse.
- Glitch: a 3-cycle high pulse on raw[2] with DEBOUNCE_CYCLES=4. Expect no level change and no pulses.
- Assert clear_toggle[0] on the same edge as a second accepted press. Expect toggle[0]=0 and press_pulse[0]=1.
- Drop rst_n while channel 3 is in DEB_HIGH with cnt=2. Expect all outputs 0 immediately; after release, a fresh full debounce is required.
- BUTTON_BANK_HOLD_EN, HOLD_CYCLES=10: hold the button. Expect hold_pulse exactly 10 cycles after press_pulse, once only. Releasing before 10 cycles produces no hold_pulse.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and defaults for the button bank.
package button_pkg;

  // Per-channel debounce state.
  typedef enum logic [1:0] {
    LOW      = 2'd0,
    DEB_HIGH = 2'd1,
    HIGH     = 2'd2,
    DEB_LOW  = 2'd3
  } btn_state_t;

  localparam int DEF_N               = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_HOLD_CYCLES     = 1000;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One debounced button channel: 2-flop synchroniser, 4-state debounce FSM,
// press/release pulses, toggle latch and, with BUTTON_BANK_HOLD_EN defined,
// a saturating long-press counter.
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_raw,
  input  logic clear_toggle,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic toggle,
  output logic hold_pulse
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be >= 1");
  end

  logic          meta, sync;
  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          toggle_q, toggle_d;

  // Two-flop synchroniser; only sync feeds the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= button_raw;
      sync <= meta;
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOW;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
    end
  end

  // Next-state: count consecutive opposite samples, commit at DEBOUNCE_CYCLES.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      LOW: if (sync) begin
        if (DEBOUNCE_CYCLES == 1) begin
          state_d = HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          state_d = DEB_HIGH;
          cnt_d   = CW'(1);
        end
      end
      DEB_HIGH: begin
        if (!sync) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HIGH: if (!sync) begin
        if (DEBOUNCE_CYCLES == 1) begin
          state_d   = LOW;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          state_d = DEB_LOW;
          cnt_d   = CW'(1);
        end
      end
      DEB_LOW: begin
        if (sync) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = LOW;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
    // Clear beats a coincident press.
    toggle_d = clear_toggle ? 1'b0 : (press_d ? ~toggle_q : toggle_q);
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign toggle        = toggle_q;

`ifdef BUTTON_BANK_HOLD_EN
  localparam int             HW        = cnt_width(HOLD_CYCLES);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_MAX  = HW'(HOLD_CYCLES);

  logic [HW-1:0] hold_cnt_q;
  logic          hold_q;

  // Long-press counter: runs while accepted level is high, saturates so the
  // pulse fires once, and is held at zero in LOW so each press starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      hold_q     <= 1'b0;
    end else begin
      hold_q <= 1'b0;
      if (state_q == HIGH || state_q == DEB_LOW) begin
        if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_q <= hold_cnt_q + HW'(1);
          hold_q     <= (hold_cnt_q == HOLD_LAST);
        end
      end else if (state_q == LOW) begin
        hold_cnt_q <= '0;
      end
    end
  end

  assign hold_pulse = hold_q;
`else
  assign hold_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_bank.sv
// Bank of N independent debounced button channels.
// Optional long-press detection: define BUTTON_BANK_HOLD_EN.
module button_bank
  import button_pkg::*;
#(
  parameter int N               = DEF_N,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] buttons_raw,
  input  logic [N-1:0] clear_toggle,
  output logic [N-1:0] level,
  output logic [N-1:0] press_pulse,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] toggle,
  output logic [N-1:0] hold_pulse
);

  // One channel instance per button; no shared state between channels.
  for (genvar i = 0; i < N; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .button_raw   (buttons_raw[i]),
      .clear_toggle (clear_toggle[i]),
      .level        (level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .toggle       (toggle[i]),
      .hold_pulse   (hold_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_bank.sv
// Testbench for button_bank (N=4, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10).
// Reference model: raw is seen two edges late; a level is accepted once D
// consecutive samples disagree with the current accepted level.
module tb_button_bank;
  localparam int N = 4;
  localparam int D = 4;
  localparam int H = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] raw, clr;
  logic [N-1:0] level, pp, rp, tog, hp;

  always #5 clk = ~clk;

  button_bank #(.N(N), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .buttons_raw  (raw),
    .clear_toggle (clr),
    .level        (level),
    .press_pulse  (pp),
    .release_pulse(rp),
    .toggle       (tog),
    .hold_pulse   (hp)
  );

  int checks = 0;
  int errors = 0;

  int           m_s1[N], m_s2[N], m_run[N], m_since[N];
  bit           m_arm[N];
  logic [N-1:0] m_lvl, m_pp, m_rp, m_tog, m_hp;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_run[i] = 0; m_since[i] = 0; m_arm[i] = 0;
    end
    m_lvl = '0; m_pp = '0; m_rp = '0; m_tog = '0; m_hp = '0;
  endtask

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      int   sv;
      logic prev;
      sv = m_s2[i];
      m_s2[i] = m_s1[i];
      m_s1[i] = int'(raw[i]);
      prev = m_lvl[i];
      m_pp[i] = 1'b0; m_rp[i] = 1'b0; m_hp[i] = 1'b0;
`ifdef BUTTON_BANK_HOLD_EN
      if (prev && m_arm[i]) begin
        m_since[i]++;
        if (m_since[i] == H) begin
          m_hp[i] = 1'b1;
          m_arm[i] = 0;
        end
      end
`endif
      if (sv != int'(m_lvl[i])) m_run[i]++;
      else m_run[i] = 0;
      if (m_run[i] == D) begin
        m_lvl[i] = sv[0];
        m_run[i] = 0;
        if (sv != 0) m_pp[i] = 1'b1;
        else m_rp[i] = 1'b1;
      end
      if (clr[i]) m_tog[i] = 1'b0;
      else if (m_pp[i]) m_tog[i] = ~m_tog[i];
      if (m_pp[i]) begin m_arm[i] = 1; m_since[i] = 0; end
      if (m_rp[i]) m_arm[i] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; raw = '0; clr = '0;
    #3;
    model_reset();
    checks++;
    if ({level, pp, rp, tog, hp} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", {level, pp, rp, tog, hp});
    end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({level, pp, rp, tog, hp} !== {m_lvl, m_pp, m_rp, m_tog, m_hp}) begin
        errors++;
        $display("FAIL reset_idle k=%0d got=%h exp=%h", k, {level, pp, rp, tog, hp},
                 {m_lvl, m_pp, m_rp, m_tog, m_hp});
      end
    end
  endtask

  task automatic test_press();
    raw[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({level, pp, rp, tog, hp} !== {m_lvl, m_pp, m_rp, m_tog, m_hp}) begin
        errors++;
        $display("FAIL press_model k=%0d got=%h exp=%h", k, {level, pp, rp, tog, hp},
                 {m_lvl, m_pp, m_rp, m_tog, m_hp});
      end
      if (k == 4) begin
        checks++;
        if ({level, pp, tog} !== 12'h000) begin
          errors++;
          $display("FAIL press_early got=%h exp=000", {level, pp, tog});
        end
      end
      if (k == 5) begin
        checks++;
        if ({level, pp, rp, tog} !== 16'h1101) begin
          errors++;
          $display("FAIL press_edge5 got=%h exp=1101", {level, pp, rp, tog});
        end
      end
      if (k == 6) begin
        checks++;
        if (pp !== 4'b0000) begin
          errors++;
          $display("FAIL press_one_cycle got=%b exp=0000", pp);
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic [14:0] pat;
    int npress;
    pat = 15'b111111111101101;  // LSB first: 1,0,1,1,0 then steady 1
    npress = 0;
    for (int k = 0; k < 15; k++) begin
      raw[1] = pat[k];
      tick();
      if (pp[1]) npress++;
      checks++;
      if ({level, pp, rp, tog, hp} !== {m_lvl, m_pp, m_rp, m_tog, m_hp}) begin
        errors++;
        $display("FAIL bounce_model k=%0d got=%h exp=%h", k, {level, pp, rp, tog, hp},
                 {m_lvl, m_pp, m_rp, m_tog, m_hp});
      end
    end
    checks++;
    if (npress != 1) begin
      errors++;
      $display("FAIL bounce_press_count got=%0d exp=1", npress);
    end
  endtask

  task automatic test_glitch();
    int nchg;
    nchg = 0;
    for (int k = 0; k < 12; k++) begin
      raw[2] = (k < 3);
      tick();
      if (level[2] || pp[2] || rp[2] || tog[2]) nchg++;
      checks++;
      if ({level, pp, rp, tog, hp} !== {m_lvl, m_pp, m_rp, m_tog, m_hp}) begin
        errors++;
        $display("FAIL glitch_model k=%0d got=%h exp=%h", k, {level, pp, rp, tog, hp},
                 {m_lvl, m_pp, m_rp, m_tog, m_hp});
      end
    end
    checks++;
    if (nchg != 0) begin
      errors++;
      $display("FAIL glitch_activity got=%0d exp=0", nchg);
    end
  endtask

  // Two release/press rounds on ch0: toggle 1->0 normally, then a press that
  // would set it to 1 but coincides with clear.
  task automatic test_clear();
    for (int pass = 0; pass < 2; pass++) begin
      raw[0] = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      raw[0] = 1'b1;
      for (int k = 0; k < 6; k++) begin
        clr[0] = (pass == 1) && (k == 5);
        tick();
        checks++;
        if ({level, pp, rp, tog, hp} !== {m_lvl, m_pp, m_rp, m_tog, m_hp}) begin
          errors++;
          $display("FAIL clear_model p=%0d k=%0d got=%h exp=%h", pass, k,
                   {level, pp, rp, tog, hp}, {m_lvl, m_pp, m_rp, m_tog, m_hp});
        end
      end
      clr[0] = 1'b0;
      checks++;
      if ({pp[0], tog[0]} !== 2'b10) begin
        errors++;
        $display("FAIL clear_press p=%0d got pp/tog=%b exp=10", pass, {pp[0], tog[0]});
      end
    end
  endtask

  task automatic test_reset_mid();
    int first;
    raw[3] = 1'b1;
    for (int k = 0; k < 4; k++) tick();  // ch3 now in DEB_HIGH, cnt=2
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({level, pp, rp, tog, hp} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got=%h exp=0", {level, pp, rp, tog, hp});
    end
    @(negedge clk) rst_n = 1'b1;
    first = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (pp[3] && first < 0) first = k;
      checks++;
      if ({level, pp, rp, tog, hp} !== {m_lvl, m_pp, m_rp, m_tog, m_hp}) begin
        errors++;
        $display("FAIL reset_mid_model k=%0d got=%h exp=%h", k, {level, pp, rp, tog, hp},
                 {m_lvl, m_pp, m_rp, m_tog, m_hp});
      end
    end
    checks++;
    if (first != D + 1) begin
      errors++;
      $display("FAIL reset_mid_latency got=%0d exp=%0d", first, D + 1);
    end
  endtask

`ifdef BUTTON_BANK_HOLD_EN
  task automatic test_hold();
    int tp, th, nh;
    raw[0] = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    raw[0] = 1'b1;
    tp = -1; th = -1; nh = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (pp[0]) tp = k;
      if (hp[0]) begin nh++; th = k; end
      checks++;
      if ({level, pp, rp, tog, hp} !== {m_lvl, m_pp, m_rp, m_tog, m_hp}) begin
        errors++;
        $display("FAIL hold_model k=%0d got=%h exp=%h", k, {level, pp, rp, tog, hp},
                 {m_lvl, m_pp, m_rp, m_tog, m_hp});
      end
    end
    checks++;
    if (nh != 1 || tp < 0 || th - tp != H) begin
      errors++;
      $display("FAIL hold_long got count=%0d delay=%0d exp count=1 delay=%0d", nh, th - tp, H);
    end
    raw[0] = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    nh = 0;
    for (int k = 0; k < 25; k++) begin
      raw[0] = (k < 8);
      tick();
      if (hp[0]) nh++;
    end
    checks++;
    if (nh != 0) begin
      errors++;
      $display("FAIL hold_short got=%0d exp=0", nh);
    end
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 6) == 0) raw[i] = ~raw[i];
        clr[i] = ($urandom_range(0, 9) == 0);
      end
      tick();
      checks++;
      if ({level, pp, rp, tog, hp} !== {m_lvl, m_pp, m_rp, m_tog, m_hp}) begin
        errors++;
        $display("FAIL random_model k=%0d got=%h exp=%h", k, {level, pp, rp, tog, hp},
                 {m_lvl, m_pp, m_rp, m_tog, m_hp});
      end
    end
    clr = '0;
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_glitch();
    test_clear();
    test_reset_mid();
`ifdef BUTTON_BANK_HOLD_EN
    test_hold();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
